ad9826_spi_responder: RTL and testbench
=======================================

Name: ad9826_spi_responder

Overview:
- Synthesizable responder for the AD9826 3-wire serial port: SLOAD, SCLK and bidirectional SDATA.
- Holds the 8 x 9-bit register file an AD9826 would hold, accepts write frames and answers read frames from a host serial master.
- Used as an on-FPGA stand-in for the ADC during bring-up and as a loopback target for the config master on a spare header.
- Fully synchronous to the system clock; serial inputs are oversampled, so clk must be at least 8x the SCLK rate (100 MHz vs 6.25 MHz in this design).

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on sload, sclk and sdata_in (minimum 2).
- FRAME_BITS, 16, bits per frame: 1 R/W, 3 address, 3 zero, 9 data.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- sload  in  1  frame select from the master, active low.
- sclk  in  1  serial clock from the master; idles low.
- sdata_in  in  1  SDATA pad input.
- sdata_out  out  1  SDATA pad output value.
- sdata_oe  out  1  SDATA pad output enable; drives the SB_IO tristate at top level.
- reg_flat  out  72  register file; register n occupies bits [9n+8:9n].
- wr_stb  out  1  one-cycle pulse when a write commits.
- wr_addr  out  3  address of the last committed write.
- wr_data  out  9  data of the last committed write.
- frame_err  out  1  one-cycle pulse on an aborted or overlong frame.

Behaviour:
- **Reset.** All registers 0, FSM in IDLE, bit_cnt 0. Outputs: sdata_out 0, sdata_oe 0, wr_stb 0, wr_addr 0, wr_data 0, frame_err 0.
- **Synchronizers.** sload, sclk and sdata_in each pass through SYNC_STAGES flops. Rise and fall detection on synced sclk and sload uses one extra flop, so total input latency is SYNC_STAGES+1 clk.
- **Frame bit order.** MSB first:
  - bit 15 = R/W (1 = read),
  - bits 14:12 = address,
  - bits 11:9 = zero,
  - bits 8:0 = data.
- **FSM states:** IDLE, SHIFT, DRIVE, DONE.
- **IDLE.** A synced sload fall clears bit_cnt and the shift register, then goes to SHIFT.
- **SHIFT.** On each sclk rise: shift in sdata_in and increment bit_cnt.
  - When bit_cnt reaches 7: latch rw and addr.
  - If rw=1, load rd_shift with reg[addr] and go to DRIVE.
  - Nonzero zero-bits are ignored.
- **DRIVE (read only).**
  - On the first sclk fall after the 7th rise: sdata_oe goes to 1 and sdata_out = rd_shift[8].
  - On each later sclk fall: shift rd_shift left.
  - After the 16th rise, the next sclk fall (or a sload rise) deasserts sdata_oe.
- **Write commit.** On the synced sload rise with bit_cnt == 16 and rw=0:
  - reg[addr] <= shift[8:0];
  - wr_addr and wr_data are updated;
  - wr_stb pulses for 1 clk on the cycle after the sload rise is detected;
  - then DONE -> IDLE.
- **Read completion.** A sload rise with bit_cnt == 16 and rw=1 changes no register and does not pulse wr_stb.
- **Short frame.** sload rise with bit_cnt < 16: no register write, frame_err pulses, sdata_oe forced to 0 the same cycle, return to IDLE.
- **Overlong frame.** An sclk rise while bit_cnt == 16: bit_cnt saturates at 16, the frame is marked bad, and at sload rise there is no commit and frame_err pulses.
- **Simultaneous events.** If an sclk rise and a sload rise are detected in the same cycle, the sload rise wins and the sclk edge is discarded.
- **Idle-line sclk.** sclk edges while sload is high are ignored.
- **Mid-frame reset.** rst_n low mid-frame immediately forces sdata_oe 0 and IDLE. The remainder of that frame is ignored until the next sload fall.
- **Drive contention.** sdata_oe is only ever 1 between bits 8 and 16 of a read frame, which matches the window in which the master releases SDATA.

Optional Feature:
- Macro: AD9826_RESP_READBACK_EN.
- Defined: read frames are served as described in Behaviour.
- Undefined:
  - DRIVE state and rd_shift are not built;
  - sdata_oe and sdata_out are tied 0;
  - read frames are parsed and completed silently, with no write and no error.

Decomposition:
- Shared package ad9826_pkg holds:
  - FRAME_BITS, ADDR_W=3, DATA_W=9;
  - register address constants: CONFIG=0, MUX=1, PGA_R=2, PGA_G=3, PGA_B=4, OFS_R=5, OFS_G=6, OFS_B=7;
  - the FSM state typedef.
- One sub-module: sync_edge_det (SYNC_STAGES synchronizer plus rise/fall pulses), instantiated for sload and sclk. sdata_in uses the synchronizer part only.

Test Plan:
- **Write.** Write frame 0x2_0AB (addr 2, data 0x0AB) at 6.25 MHz -> reg_flat[26:18]=0x0AB; wr_stb one pulse with wr_addr=2, wr_data=0x0AB; other registers 0.
- **Readback.** Write addr 5 = 0x1C3, then read frame 0xD000 -> sdata_oe high for exactly bits 8..16; master-sampled bits = 1_1100_0011; no wr_stb.
- **Short frame.** sload rises after 10 sclk -> frame_err pulse; register file unchanged; sdata_oe 0 within SYNC_STAGES+2 clk.
- **Overlong frame.** 18 sclk in one frame -> no commit; frame_err pulse.
- **Mid-frame reset.** Assert rst_n low at bit 9 of a read -> sdata_oe 0 immediately; registers 0; the next full write frame commits correctly.
- **Macro off.** Build without AD9826_RESP_READBACK_EN and issue a read frame -> sdata_oe stays 0 throughout; writes still commit.

Source files
------------

// File: rtl/ad9826_spi_responder_pkg.sv
// Shared constants, register map and FSM state type for the AD9826 serial-port responder.
// Header decode helper used once the R/W and address bits of a frame have been shifted in.
package ad9826_pkg;

   localparam int FRAME_BITS = 16;
   localparam int ADDR_W     = 3;
   localparam int DATA_W     = 9;
   localparam int NUM_REGS   = 8;

   localparam logic [ADDR_W-1:0] REG_CONFIG = 3'd0;
   localparam logic [ADDR_W-1:0] REG_MUX    = 3'd1;
   localparam logic [ADDR_W-1:0] REG_PGA_R  = 3'd2;
   localparam logic [ADDR_W-1:0] REG_PGA_G  = 3'd3;
   localparam logic [ADDR_W-1:0] REG_PGA_B  = 3'd4;
   localparam logic [ADDR_W-1:0] REG_OFS_R  = 3'd5;
   localparam logic [ADDR_W-1:0] REG_OFS_G  = 3'd6;
   localparam logic [ADDR_W-1:0] REG_OFS_B  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DRIVE,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic              rw;
      logic [ADDR_W-1:0] addr;
   } hdr_t;

   function automatic hdr_t hdr_decode(input logic [ADDR_W:0] rw_addr);
      return hdr_t'(rw_addr);
   endfunction

endpackage

// File: rtl/ad9826_spi_responder_sync_edge_det.sv
// Multi-flop synchronizer with one extra flop for single-cycle rise/fall pulses.
// Latency SYNC_STAGES clk to the pulse; no backpressure, every edge is reported once.
module sync_edge_det
   import ad9826_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   // Reset to 0 even for idle-high lines: a release with the line low then shows no fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/ad9826_spi_responder.sv
// AD9826 3-wire serial-port responder: 8x9-bit register file, write commit and (with
// AD9826_RESP_READBACK_EN) read drive; SYNC_STAGES+1 clk input latency, no backpressure.
module ad9826_spi_responder
   import ad9826_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = ad9826_pkg::FRAME_BITS
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         sload,
   input  logic                         sclk,
   input  logic                         sdata_in,
   output logic                         sdata_out,
   output logic                         sdata_oe,
   output logic [NUM_REGS*DATA_W-1:0]   reg_flat,
   output logic                         wr_stb,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic [DATA_W-1:0]            wr_data,
   output logic                         frame_err
);

   localparam int                CNT_W    = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
   // Count just before the last zero bit: R/W and address sit in shift_q[5:2] here.
   localparam logic [CNT_W-1:0]  CNT_HDR  = CNT_W'(FRAME_BITS - DATA_W - 1);

   logic sload_rise, sload_fall, sclk_rise, sclk_fall;

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sload_det (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (sload),
      .rise (sload_rise),
      .fall (sload_fall)
   );

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_det (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (sclk),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   // Same depth as the sclk path so the data bit lines up with the detected rise.
   logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
   logic                   sdi;

   always_comb begin
      sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdata_in};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sdi_sync_q <= '0;
      end else begin
         sdi_sync_q <= sdi_sync_d;
      end
   end

   assign sdi = sdi_sync_q[SYNC_STAGES-1];

   state_e             state_q;
   logic [CNT_W-1:0]   bit_cnt_q;
   logic [DATA_W-1:0]  shift_q;
   logic               rw_q;
   logic [ADDR_W-1:0]  addr_q;
   logic               bad_q;
   logic [DATA_W-1:0]  regs_q [NUM_REGS];
   logic               wr_stb_q;
   logic [ADDR_W-1:0]  wr_addr_q;
   logic [DATA_W-1:0]  wr_data_q;
   logic               frame_err_q;
   hdr_t               hdr;

`ifdef AD9826_RESP_READBACK_EN
   logic [DATA_W-1:0]  rd_shift_q;
   logic               oe_q;
   logic               out_q;
`else
   logic               unused_sclk_fall;
   assign unused_sclk_fall = sclk_fall;
`endif

   assign hdr = hdr_decode(shift_q[ADDR_W+2:2]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         bad_q       <= 1'b0;
         wr_stb_q    <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         frame_err_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef AD9826_RESP_READBACK_EN
         rd_shift_q  <= '0;
         oe_q        <= 1'b0;
         out_q       <= 1'b0;
`endif
      end else begin
         wr_stb_q    <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (sload_fall) begin
                  bit_cnt_q <= '0;
                  shift_q   <= '0;
                  rw_q      <= 1'b0;
                  bad_q     <= 1'b0;
                  state_q   <= ST_SHIFT;
               end
            end
            ST_SHIFT, ST_DRIVE: begin
               // sload rise takes priority over any sclk edge seen in the same cycle.
               if (sload_rise) begin
`ifdef AD9826_RESP_READBACK_EN
                  oe_q <= 1'b0;
`endif
                  if (bit_cnt_q == CNT_FULL && !bad_q) begin
                     if (!rw_q) begin
                        regs_q[addr_q] <= shift_q;
                        wr_addr_q      <= addr_q;
                        wr_data_q      <= shift_q;
                        wr_stb_q       <= 1'b1;
                     end
                     state_q <= ST_DONE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= ST_IDLE;
                  end
               end else if (sclk_rise) begin
                  if (bit_cnt_q == CNT_FULL) begin
                     bad_q <= 1'b1;
                  end else begin
                     shift_q   <= {shift_q[DATA_W-2:0], sdi};
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     if (bit_cnt_q == CNT_HDR) begin
                        rw_q   <= hdr.rw;
                        addr_q <= hdr.addr;
`ifdef AD9826_RESP_READBACK_EN
                        if (hdr.rw) begin
                           rd_shift_q <= regs_q[hdr.addr];
                           state_q    <= ST_DRIVE;
                        end
`endif
                     end
                  end
               end
`ifdef AD9826_RESP_READBACK_EN
               else if (sclk_fall && state_q == ST_DRIVE) begin
                  if (bit_cnt_q == CNT_FULL) begin
                     oe_q <= 1'b0;
                  end else begin
                     oe_q       <= 1'b1;
                     out_q      <= rd_shift_q[DATA_W-1];
                     rd_shift_q <= {rd_shift_q[DATA_W-2:0], 1'b0};
                  end
               end
`endif
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef AD9826_RESP_READBACK_EN
   // Release the pad in the detection cycle rather than one clock later.
   assign sdata_oe  = oe_q & ~sload_rise;
   assign sdata_out = out_q;
`else
   assign sdata_oe  = 1'b0;
   assign sdata_out = 1'b0;
`endif

   always_comb begin
      reg_flat = '0;
      for (int i = 0; i < NUM_REGS; i++) reg_flat[i*DATA_W +: DATA_W] = regs_q[i];
   end

   assign wr_stb    = wr_stb_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ad9826_spi_responder.sv
// Bench for ad9826_spi_responder: bit-banged 6.25 MHz host master, event scoreboard on
// wr_stb/frame_err, direct checks of the register file and the read drive window.
module tb_ad9826_spi_responder;
   import ad9826_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sload = 1'b1;
   logic        sclk = 1'b0;
   logic        sdata_in = 1'b0;
   logic        sdata_out, sdata_oe, wr_stb, frame_err;
   logic [71:0] reg_flat;
   logic [2:0]  wr_addr;
   logic [8:0]  wr_data;

   ad9826_spi_responder #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sload    (sload),
      .sclk     (sclk),
      .sdata_in (sdata_in),
      .sdata_out(sdata_out),
      .sdata_oe (sdata_oe),
      .reg_flat (reg_flat),
      .wr_stb   (wr_stb),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      bit         err;
      logic [2:0] addr;
      logic [8:0] data;
   } ev_t;

   ev_t        exp_q[$];
   logic [8:0] model [8];

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [71:0] model_flat();
      logic [71:0] f = '0;
      for (int i = 0; i < 8; i++) f[i*9 +: 9] = model[i];
      return f;
   endfunction

   // Monitor: every wr_stb / frame_err pulse must match the next queued expectation.
   always @(negedge clk) begin
      ev_t e;
      if (rst_n && (wr_stb || frame_err)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", 72'({wr_stb, frame_err}), 72'd0);
         end else begin
            e = exp_q.pop_front();
            check("event_kind", 72'({wr_stb, frame_err}), e.err ? 72'd1 : 72'd2);
            if (!e.err) begin
               check("event_wr_addr", 72'(wr_addr), 72'(e.addr));
               check("event_wr_data", 72'(wr_data), 72'(e.data));
            end
         end
      end
   end

   // Host master: data set up while sclk is low, responder output sampled on sclk rise.
   task automatic frame(input logic [15:0] word, input int nbits, input int rst_at,
                        output logic [15:0] rd_bits, output logic [15:0] oe_bits,
                        output logic oe_after);
      rd_bits = '0;
      oe_bits = '0;
      sload   = 1'b0;
      #80;
      for (int i = 0; i < nbits; i++) begin
         sdata_in = (i < 16) ? word[15-i] : 1'b0;
         #80;
         sclk = 1'b1;
         if (i < 16) begin
            rd_bits[15-i] = sdata_out;
            oe_bits[15-i] = sdata_oe;
         end
         if (i + 1 == rst_at) begin
`ifdef AD9826_RESP_READBACK_EN
            check("mid_rst_oe_before", 72'(sdata_oe), 72'd1);
`endif
            rst_n = 1'b0;
            #1;
            check("mid_rst_oe", 72'(sdata_oe), 72'd0);
            check("mid_rst_regs", reg_flat, 72'd0);
            #19;
            rst_n = 1'b1;
            for (int r = 0; r < 8; r++) model[r] = '0;
         end
         #80;
         sclk = 1'b0;
      end
      #80;
      sload = 1'b1;
      #36;
      oe_after = sdata_oe;
      #164;
   endtask

   task automatic do_write(input logic [2:0] a, input logic [8:0] d, input string name);
      logic [15:0] rb, ob;
      logic        oa;
      exp_q.push_back('{err: 1'b0, addr: a, data: d});
      frame({1'b0, a, 3'b000, d}, 16, -1, rb, ob, oa);
      model[a] = d;
      check({name, "_regs"}, reg_flat, model_flat());
      check({name, "_oe"}, 72'(ob), 72'd0);
   endtask

   initial begin
      logic [15:0] rb, ob;
      logic        oa;
      for (int r = 0; r < 8; r++) model[r] = '0;

      #20;
      check("rst_regs", reg_flat, 72'd0);
      check("rst_oe", 72'(sdata_oe), 72'd0);
      check("rst_out", 72'(sdata_out), 72'd0);
      check("rst_wr_stb", 72'(wr_stb), 72'd0);
      check("rst_wr_addr", 72'(wr_addr), 72'd0);
      check("rst_wr_data", 72'(wr_data), 72'd0);
      check("rst_frame_err", 72'(frame_err), 72'd0);
      #10;
      rst_n = 1'b1;
      #50;

      // Frame 0x20AB: PGA_R <= 0x0AB, lands in reg_flat[26:18].
      do_write(REG_PGA_R, 9'h0AB, "write_pga_r");
      check("write_pga_r_field", 72'(reg_flat[26:18]), 72'h0AB);
      check("write_pga_r_wr_addr", 72'(wr_addr), 72'd2);

      do_write(REG_OFS_R, 9'h1C3, "write_ofs_r");
      check("write_ofs_r_field", 72'(reg_flat[53:45]), 72'h1C3);

      // Read frame 0xD000 (addr 5): pad driven for frame bits 8..16 only.
      frame(16'hD000, 16, -1, rb, ob, oa);
`ifdef AD9826_RESP_READBACK_EN
      check("read_oe_window", 72'(ob), 72'h01FF);
      check("read_data", 72'(rb[8:0]), 72'h1C3);
`else
      check("read_oe_window", 72'(ob), 72'd0);
`endif
      check("read_oe_after", 72'(oa), 72'd0);
      check("read_regs", reg_flat, model_flat());
      check("read_wr_addr_kept", 72'(wr_addr), 72'd5);
      check("read_wr_data_kept", 72'(wr_data), 72'h1C3);

      // Short read frame: 10 sclk, pad released within SYNC_STAGES+2 clk of sload rise.
      exp_q.push_back('{err: 1'b1, addr: 3'd0, data: 9'd0});
      frame(16'hD000, 10, -1, rb, ob, oa);
      check("short_oe_after", 72'(oa), 72'd0);
      check("short_regs", reg_flat, model_flat());

      // Short write frame must not commit.
      exp_q.push_back('{err: 1'b1, addr: 3'd0, data: 9'd0});
      frame(16'h3155, 10, -1, rb, ob, oa);
      check("short_wr_regs", reg_flat, model_flat());

      // Overlong write frame: 18 sclk, no commit.
      exp_q.push_back('{err: 1'b1, addr: 3'd0, data: 9'd0});
      frame(16'h7055, 18, -1, rb, ob, oa);
      check("overlong_regs", reg_flat, model_flat());
      check("overlong_oe_after", 72'(oa), 72'd0);

      // sclk activity with sload high is ignored.
      for (int k = 0; k < 4; k++) begin
         sdata_in = k[0];
         #80;
         sclk = 1'b1;
         #80;
         sclk = 1'b0;
      end
      #200;
      check("idle_sclk_regs", reg_flat, model_flat());

      // Reset at bit 9 of a read; rest of that frame ignored, next write commits.
      frame(16'hD000, 16, 9, rb, ob, oa);
      check("post_rst_oe_after", 72'(oa), 72'd0);
      check("post_rst_regs", reg_flat, 72'd0);
      do_write(REG_PGA_R, 9'h0AB, "post_rst_write");
      do_write(REG_OFS_B, 9'h1FF, "write_ofs_b");

      #200;
      check("scoreboard_drained", 72'(exp_q.size()), 72'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
